sa_matmul_engine: RTL



---
 rtl/sa_pkg.sv | 13 +
 rtl/sa_pe.sv | 55 +++++
 rtl/sa_matmul_engine.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/sa_pkg.sv
// sa_pkg: shared types and constants for the systolic matrix-multiply engine
// Contents: FSM state enum, default operand/accumulator widths, constant clog2 helper
package sa_pkg;
   typedef enum logic [2:0] {IDLE, STREAM, FLUSH, DRAIN, DONE} state_t;
   localparam int DEF_DW = 16;
   localparam int DEF_AW = 32;
   function automatic int clog2(input int v);
      int r;
      r = 0;
      for (int p = 1; p < v; p = p * 2) r++;
      return r < 1 ? 1 : r;
   endfunction
endpackage

// File: rtl/sa_pe.sv
// sa_pe: one output-stationary processing element of the systolic array
// Ports: clk, rst (sync, active-high); clr clears the accumulator at job start;
//        a_in/av_in from the left, b_in/bv_in from above; a_out/av_out right,
//        b_out/bv_out down (1-cycle forward); acc result; sat (SA_SATURATE_EN only)
//        flags a saturating update this cycle.
module sa_pe #(
   parameter int DW = 16,
   parameter int AW = 32
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 clr,
   input  logic signed [DW-1:0] a_in,
   input  logic signed [DW-1:0] b_in,
   input  logic                 av_in,
   input  logic                 bv_in,
   output logic signed [DW-1:0] a_out,
   output logic signed [DW-1:0] b_out,
   output logic                 av_out,
   output logic                 bv_out,
   output logic signed [AW-1:0] acc
`ifdef SA_SATURATE_EN
   ,
   output logic                 sat
`endif
);
   logic signed [2*DW-1:0] p;
   logic signed [AW-1:0]   nxt;
   logic                   fire;
   assign fire = av_in && bv_in;
   assign p = a_in * b_in;
`ifdef SA_SATURATE_EN
   // one guard bit exposes signed overflow; clamp towards its sign
   logic signed [AW:0] s;
   assign s = (AW+1)'(acc) + (AW+1)'(p);
   assign sat = fire && (s[AW] != s[AW-1]);
   assign nxt = (s[AW] != s[AW-1]) ? {s[AW], {(AW-1){~s[AW]}}} : s[AW-1:0];
`else
   assign nxt = acc + AW'(p);
`endif
   always_ff @(posedge clk)
      if (rst) begin
         a_out  <= '0;
         b_out  <= '0;
         av_out <= 1'b0;
         bv_out <= 1'b0;
         acc    <= '0;
      end else begin
         a_out  <= a_in;
         b_out  <= b_in;
         av_out <= av_in;
         bv_out <= bv_in;
         acc    <= clr ? '0 : fire ? nxt : acc;
      end
endmodule

// File: rtl/sa_matmul_engine.sv
// sa_matmul_engine: N x N output-stationary systolic engine computing C = A x B
// Ports: clk, rst (sync, active-high); start/k_len job launch (IDLE only);
//        in_valid/in_ready with a_data (A column) and b_data (B row) per beat;
//        c_valid/c_ready with c_data (row of C), c_row, c_last; busy; done pulse;
//        sat_flag (sticky, only when SA_SATURATE_EN is defined).
module sa_matmul_engine
   import sa_pkg::*;
#(
   parameter int N  = 4,
   parameter int DW = DEF_DW,
   parameter int AW = DEF_AW,
   parameter int KW = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [KW-1:0]         k_len,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [N*DW-1:0]       a_data,
   input  logic [N*DW-1:0]       b_data,
   output logic                  c_valid,
   input  logic                  c_ready,
   output logic [N*AW-1:0]       c_data,
   output logic [clog2(N)-1:0]   c_row,
   output logic                  c_last,
   output logic                  busy,
   output logic                  done
`ifdef SA_SATURATE_EN
   ,
   output logic                  sat_flag
`endif
);
   localparam int RW = clog2(N);
   localparam int FW = clog2(2*N);
   if (AW < 2*DW) begin : g_bad_aw
      $error("sa_matmul_engine: AW must be >= 2*DW");
   end
   state_t          state, nxt;
   logic [KW-1:0]   k_cnt;
   logic [FW-1:0]   f_cnt;
   logic            go, beat, hs;
   logic [DW-1:0]   ad [N][N+1];
   logic            av [N][N+1];
   logic [DW-1:0]   bd [N+1][N];
   logic            bv [N+1][N];
   logic [AW-1:0]   acc [N][N];
   logic [N*N-1:0]  sv;
   assign go       = start && state == IDLE;
   assign beat     = in_valid && in_ready;
   assign hs       = c_valid && c_ready;
   assign in_ready = state == STREAM;
   assign c_valid  = state == DRAIN;
   assign c_last   = c_valid && c_row == RW'(N-1);
   assign busy     = state != IDLE;
   assign done     = state == DONE;
   always_comb begin
      nxt = state;
      case (state)
         IDLE:    if (go) nxt = k_len == '0 ? DRAIN : STREAM;
         STREAM:  if (beat && k_cnt == KW'(1)) nxt = FLUSH;
         FLUSH:   if (f_cnt == FW'(2*N-2)) nxt = DRAIN;
         DRAIN:   if (hs && c_last) nxt = DONE;
         default: nxt = IDLE;
      endcase
   end
   always_ff @(posedge clk)
      if (rst) state <= IDLE;
      else     state <= nxt;
   always_ff @(posedge clk)
      if (rst) begin
         k_cnt <= '0;
         f_cnt <= '0;
         c_row <= '0;
      end else begin
         k_cnt <= go ? k_len : beat ? k_cnt - KW'(1) : k_cnt;
         f_cnt <= state == FLUSH ? f_cnt + FW'(1) : '0;
         c_row <= go ? '0 : hs ? (c_last ? '0 : c_row + RW'(1)) : c_row;
      end
   // lane i of A and B share one tag chain since both are delayed i cycles
   for (genvar i = 0; i < N; i++) begin : g_sk
      logic [DW-1:0] sa [i+1];
      logic [DW-1:0] sb [i+1];
      logic [i:0]    v;
      always_ff @(posedge clk)
         if (rst) begin
            v <= '0;
            for (int s = 0; s <= i; s++) begin
               sa[s] <= '0;
               sb[s] <= '0;
            end
         end else begin
            sa[0] <= a_data[i*DW +: DW];
            sb[0] <= b_data[i*DW +: DW];
            v[0]  <= beat;
            for (int s = 1; s <= i; s++) begin
               sa[s] <= sa[s-1];
               sb[s] <= sb[s-1];
               v[s]  <= v[s-1];
            end
         end
      assign ad[i][0] = sa[i];
      assign av[i][0] = v[i];
      assign bd[0][i] = sb[i];
      assign bv[0][i] = v[i];
   end
   for (genvar i = 0; i < N; i++) begin : g_r
      for (genvar j = 0; j < N; j++) begin : g_c
         sa_pe #(.DW(DW), .AW(AW)) u_pe (
            .clk    (clk),
            .rst    (rst),
            .clr    (go),
            .a_in   (ad[i][j]),
            .b_in   (bd[i][j]),
            .av_in  (av[i][j]),
            .bv_in  (bv[i][j]),
            .a_out  (ad[i][j+1]),
            .b_out  (bd[i+1][j]),
            .av_out (av[i][j+1]),
            .bv_out (bv[i+1][j]),
            .acc    (acc[i][j])
`ifdef SA_SATURATE_EN
            ,
            .sat    (sv[i*N+j])
`endif
         );
`ifndef SA_SATURATE_EN
         assign sv[i*N+j] = 1'b0;
`endif
      end
   end
   always_comb begin
      c_data = '0;
      for (int j = 0; j < N; j++) c_data[j*AW +: AW] = c_valid ? acc[c_row][j] : '0;
   end
`ifdef SA_SATURATE_EN
   always_ff @(posedge clk)
      if (rst) sat_flag <= 1'b0;
      else     sat_flag <= go ? 1'b0 : sat_flag | (|sv);
`endif
endmodule
